ch_sample_scheduler: RTL

CH_SAMPLE_SCHEDULER -- requirements
Module: ch_sample_scheduler

---
 rtl/sched_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/ch_sample_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sched_pkg : shared types and default sizes for ch_sample_scheduler     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package sched_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ROM_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter, pointer advances on each grant  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module rr_arb2
    import sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    ch_tag_t r_last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (r_last == CH1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset to "ch1 last granted" so ch0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= CH1;
        end else if (gnt[0]) begin
            r_last <= CH0;
        end else if (gnt[1]) begin
            r_last <= CH1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ch_sample_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ch_sample_scheduler : shares one sine ROM between two sample channels  |
// | Optional grant counters when SCHED_STATS_EN is defined.   Rev 1.0      |
// +------------------------------------------------------------------------+
module ch_sample_scheduler
    import sched_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = DEF_ROM_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              ch0_req,
    input  logic              ch1_req,
    input  logic [ADDR_W-1:0] ch0_addr,
    input  logic [ADDR_W-1:0] ch1_addr,
    output logic              ch0_gnt,
    output logic              ch1_gnt,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ch0_valid,
    output logic              ch1_valid,
    output logic [DATA_W-1:0] ch0_data,
    output logic [DATA_W-1:0] ch1_data,
    output logic              busy
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]       ch0_cnt,
    output logic [31:0]       ch1_cnt
`endif
);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic                w_issue_en;
    logic [1:0]          w_gnt;
    logic                w_pipe_busy;
    logic [ROM_LAT-1:0]  r_pipe_vld;
    ch_tag_t             r_pipe_tag [ROM_LAT];
    logic                r_ch0_valid;
    logic                r_ch1_valid;
    logic [DATA_W-1:0]   r_ch0_data;
    logic [DATA_W-1:0]   r_ch1_data;

    assign w_pipe_busy = |r_pipe_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (run) w_state_nxt = RUN;
            RUN:     if (!run) w_state_nxt = DRAIN;
            DRAIN: begin
                if (run) begin
                    w_state_nxt = RUN;
                end else if (!w_pipe_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_issue_en = (r_state == RUN);
        busy       = (r_state != IDLE) || w_pipe_busy;
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_issue_en),
        .req   ({ch1_req, ch0_req}),
        .gnt   (w_gnt)
    );

    assign ch0_gnt  = w_gnt[0];
    assign ch1_gnt  = w_gnt[1];
    assign rom_en   = |w_gnt;
    assign rom_addr = w_gnt[1] ? ch1_addr : (w_gnt[0] ? ch0_addr : '0);

    // Tag/valid pair reaches the last stage exactly when rom_data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipe_tag[i] <= CH0;
            end
            r_ch0_valid <= 1'b0;
            r_ch1_valid <= 1'b0;
            r_ch0_data  <= '0;
            r_ch1_data  <= '0;
        end else begin
            r_pipe_vld[0] <= rom_en;
            r_pipe_tag[0] <= w_gnt[1] ? CH1 : CH0;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            r_ch0_valid <= r_pipe_vld[ROM_LAT-1] && (r_pipe_tag[ROM_LAT-1] == CH0);
            r_ch1_valid <= r_pipe_vld[ROM_LAT-1] && (r_pipe_tag[ROM_LAT-1] == CH1);
            if (r_pipe_vld[ROM_LAT-1] && (r_pipe_tag[ROM_LAT-1] == CH0)) begin
                r_ch0_data <= rom_data;
            end
            if (r_pipe_vld[ROM_LAT-1] && (r_pipe_tag[ROM_LAT-1] == CH1)) begin
                r_ch1_data <= rom_data;
            end
        end
    end

    assign ch0_valid = r_ch0_valid;
    assign ch1_valid = r_ch1_valid;
    assign ch0_data  = r_ch0_data;
    assign ch1_data  = r_ch1_data;

`ifdef SCHED_STATS_EN
    logic [31:0] r_ch0_cnt;
    logic [31:0] r_ch1_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch0_cnt <= 32'd0;
            r_ch1_cnt <= 32'd0;
        end else begin
            if (w_gnt[0]) r_ch0_cnt <= r_ch0_cnt + 32'd1;
            if (w_gnt[1]) r_ch1_cnt <= r_ch1_cnt + 32'd1;
        end
    end

    assign ch0_cnt = r_ch0_cnt;
    assign ch1_cnt = r_ch1_cnt;
`endif

endmodule
`default_nettype wire
